dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back data cache between the ALU result bus and the 32-bit-block data memory.
- Consumes the ALU RESULT as the byte ADDRESS for load/store instructions.
- Asserts BUSYWAIT to stall the CPU pipeline on a miss.
- Runs a refill/write-back state machine against the slow memory handshake.

Parameters:
- NUM_LINES, 8, number of cache lines (index width = log2 = 3).
- BLOCK_BYTES, 4, bytes per line (offset width = 2; memory word = 32 bits).

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RESET  in  1  synchronous, active-low reset
- READ  in  1  CPU load request, held until BUSYWAIT low
- WRITE  in  1  CPU store request, held until BUSYWAIT low
- ADDRESS  in  8  byte address from ALU RESULT: tag[7:5], index[4:2], offset[1:0]
- WRITEDATA  in  8  store data
- READDATA  out  8  load data
- BUSYWAIT  out  1  CPU stall
- MEM_READ  out  1  memory block read request
- MEM_WRITE  out  1  memory block write request
- MEM_ADDRESS  out  6  block address {tag,index}
- MEM_WRITEDATA  out  32  block being written back
- MEM_READDATA  in  32  refill block
- MEM_BUSYWAIT  in  1  memory busy; falls for one cycle when transfer completes

Behaviour:
- Storage per line:
  - valid bit, dirty bit, 3-bit tag, 32-bit data (byte k = bits 8k+7:8k).
- Reset (RESET=0 at a rising edge):
  - all valid/dirty cleared; FSM to IDLE.
  - READDATA=0, BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - Reset mid-transaction aborts it: memory strobes drop at that edge and dirty data is discarded.
- Request decode:
  - access = READ|WRITE.
  - READ and WRITE both high is treated as WRITE.
  - hit = valid[index] & (tag[index]==ADDRESS[7:5]).
- BUSYWAIT is combinational:
  - 1 when access & (!hit | state!=IDLE).
  - 0 when idle or on a hit in IDLE.
  - No stall cycle on a hit.
- Read hit:
  - READDATA = selected byte, combinational, same cycle.
  - READDATA holds its last value when READ is low.
- Write hit:
  - byte written and dirty set at the next rising edge.
  - BUSYWAIT stays 0.
- FSM states: IDLE, WRITE_BACK, MEM_READ, UPDATE.
  - IDLE -> WRITE_BACK: access & miss & dirty.
  - IDLE -> MEM_READ: access & miss & !dirty.
  - WRITE_BACK:
    - MEM_WRITE=1, MEM_ADDRESS={old tag,index}, MEM_WRITEDATA=line data.
    - when MEM_BUSYWAIT=0 -> MEM_READ.
  - MEM_READ:
    - MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2].
    - when MEM_BUSYWAIT=0 -> UPDATE.
  - UPDATE:
    - line data <= MEM_READDATA, tag <= ADDRESS[7:5], valid=1, dirty=0.
    - -> IDLE.
    - The access then hits in IDLE; a write completes one edge later.
- Memory strobes:
  - MEM_READ and MEM_WRITE are never both 1.
  - Both are 0 in IDLE and UPDATE.
- Miss latency:
  - clean miss = memory latency + 2 cycles.
  - dirty miss adds one full write-back transfer.
- Request dropped while in WRITE_BACK/MEM_READ (CPU protocol violation):
  - the transfer still completes and the line is still refilled.
  - the FSM then returns to IDLE.
- ADDRESS changes are legal only while BUSYWAIT=0.

Decomposition:
- Package dcache_pkg:
  - state encoding (IDLE=2'b00, WRITE_BACK=2'b01, MEM_READ=2'b10, UPDATE=2'b11).
  - field widths TAG_W=3, IDX_W=3, OFF_W=2.
  - BLOCK_W=32.
- One sub-module, dcache_fsm: state register, next-state logic and memory strobes.
- Storage arrays and hit logic stay in dcache_ctrl.

Test Plan:
- Reset then READ ADDRESS=8'h14:
  - BUSYWAIT=1, MEM_READ=1, MEM_ADDRESS=6'h05.
  - memory returns 32'hDDCCBBAA -> after UPDATE, READDATA=8'hAA and BUSYWAIT=0.
- Read hit: READ ADDRESS=8'h17 after previous refill -> READDATA=8'hDD the same cycle, no MEM_READ, BUSYWAIT never 1.
- Write hit: WRITE ADDRESS=8'h15, WRITEDATA=8'h3C -> BUSYWAIT=0; subsequent READ 8'h15 returns 8'h3C; line dirty.
- Dirty eviction: WRITE to 8'h35 (same index 5, tag 1):
  - WRITE_BACK with MEM_ADDRESS=6'h05, MEM_WRITEDATA=32'hDDCC3CAA.
  - then MEM_READ with MEM_ADDRESS=6'h0D, then UPDATE, then the write completes.
- Reset asserted during MEM_READ:
  - MEM_READ=0 and BUSYWAIT=0 after that edge.
  - READ 8'h14 then misses again (all lines invalid).
- READ and WRITE both high on a hit, WRITEDATA=8'h5A -> treated as write; line dirty and byte = 8'h5A.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared widths, state encoding and helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int NUM_LINES   = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int TAG_W       = 3;
  localparam int IDX_W       = $clog2(NUM_LINES);
  localparam int OFF_W       = $clog2(BLOCK_BYTES);
  localparam int BLOCK_W     = 32;
  localparam int ADDR_W      = TAG_W + IDX_W + OFF_W;
  localparam int BADDR_W     = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WRITE_BACK = 2'b01,
    MEM_READ   = 2'b10,
    UPDATE     = 2'b11
  } state_t;

  // Picks byte 'off' out of a block; byte k lives in bits 8k+7:8k.
  function automatic logic [7:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                            input logic [OFF_W-1:0]   off);
    return blk[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_fsm.sv
// Miss-handling sequencer: decides when to write back, when to refill, and
// drives the registered memory strobes, block address and write-back data.
module dcache_fsm
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               access,
  input  logic               hit,
  input  logic               dirty_line,
  input  logic [TAG_W-1:0]   old_tag,
  input  logic [IDX_W-1:0]   index,
  input  logic [BLOCK_W-1:0] line_data,
  input  logic [BADDR_W-1:0] req_block,
  input  logic               mem_busywait,
  output state_t             state,
  output logic               mem_read,
  output logic               mem_write,
  output logic [BADDR_W-1:0] mem_address,
  output logic [BLOCK_W-1:0] mem_writedata
);

  // Block that missed, captured at the miss so the refill target cannot drift
  // if the CPU drops its request while a transfer is still running.
  logic [BADDR_W-1:0] miss_block;

  // State register and registered memory strobes; transfers always run to
  // completion once started, only reset can abort them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      miss_block    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access && !hit) begin
            miss_block <= req_block;
            if (dirty_line) begin
              state         <= WRITE_BACK;
              mem_write     <= 1'b1;
              mem_address   <= {old_tag, index};
              mem_writedata <= line_data;
            end else begin
              state       <= MEM_READ;
              mem_read    <= 1'b1;
              mem_address <= req_block;
            end
          end
        end
        WRITE_BACK: begin
          if (!mem_busywait) begin
            state       <= MEM_READ;
            mem_write   <= 1'b0;
            mem_read    <= 1'b1;
            mem_address <= miss_block;
          end
        end
        MEM_READ: begin
          if (!mem_busywait) begin
            state    <= UPDATE;
            mem_read <= 1'b0;
          end
        end
        UPDATE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache: line storage, hit detection, CPU-side
// read/write paths and the stall signal; miss sequencing lives in dcache_fsm.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [ADDR_W-1:0]  address,
  input  logic [7:0]         writedata,
  output logic [7:0]         readdata,
  output logic               busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [BADDR_W-1:0] mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [BLOCK_W-1:0]   data_q [NUM_LINES];
  logic [7:0]           readdata_q;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] index;
  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] upd_index;
  logic             access;
  logic             is_read;
  logic             is_write;
  logic             hit;
  logic             rd_hit;
  logic             wr_hit;
  logic [7:0]       sel_byte;
  state_t           state;

  assign tag       = address[ADDR_W-1 -: TAG_W];
  assign index     = address[OFF_W +: IDX_W];
  assign offset    = address[OFF_W-1:0];
  assign upd_index = mem_address[IDX_W-1:0];

  assign access   = read | write;
  assign is_write = write;
  assign is_read  = read & ~write;
  assign hit      = valid_q[index] && (tag_q[index] == tag);
  assign rd_hit   = is_read && hit && (state == IDLE);
  assign wr_hit   = is_write && hit && (state == IDLE);
  assign sel_byte = block_byte(data_q[index], offset);

  assign busywait = access && (!hit || (state != IDLE));
  assign readdata = rd_hit ? sel_byte : readdata_q;

  // Line status bits and the held read value; reset invalidates everything,
  // which also throws away any dirty data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      readdata_q <= '0;
    end else begin
      if (state == UPDATE) begin
        valid_q[upd_index] <= 1'b1;
        dirty_q[upd_index] <= 1'b0;
      end else if (wr_hit) begin
        dirty_q[index] <= 1'b1;
      end
      if (rd_hit) begin
        readdata_q <= sel_byte;
      end
    end
  end

  // Tag and data arrays: refill from memory in UPDATE, byte store on a hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == UPDATE) begin
        data_q[upd_index] <= mem_readdata;
        tag_q[upd_index]  <= mem_address[BADDR_W-1 -: TAG_W];
      end else if (wr_hit) begin
        data_q[index][{offset, 3'b000} +: 8] <= writedata;
      end
    end
  end

  dcache_fsm u_fsm (
    .clk           (clk),
    .reset         (reset),
    .access        (access),
    .hit           (hit),
    .dirty_line    (dirty_q[index] & valid_q[index]),
    .old_tag       (tag_q[index]),
    .index         (index),
    .line_data     (data_q[index]),
    .req_block     (address[ADDR_W-1:OFF_W]),
    .mem_busywait  (mem_busywait),
    .state         (state),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata)
  );

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: slow block memory model, memory-transaction
// scoreboard, table of hit vectors and hand-written miss/reset sequences.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  localparam int MEM_LAT  = 3;
  localparam int MAX_WAIT = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [7:0]  writedata = 8'h00;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  // Memory model contents and handshake state
  logic [31:0] mem_array [64];
  int          mem_cnt = 0;
  logic        mem_done = 1'b0;

  function automatic logic [31:0] block_init(input int b);
    if (b == 5) return 32'hDDCCBBAA;
    return {8'(b + 48), 8'(b + 32), 8'(b + 16), 8'(b)};
  endfunction

  assign mem_busywait = (mem_read || mem_write) && !mem_done;

  // Memory completes a transfer MEM_LAT edges after the strobe appears,
  // then drops busywait for exactly one cycle.
  always @(posedge clk) begin
    if (!reset) begin
      mem_cnt  <= 0;
      mem_done <= 1'b0;
    end else if ((mem_read || mem_write) && !mem_done) begin
      if (mem_cnt == MEM_LAT - 1) begin
        mem_done <= 1'b1;
        mem_cnt  <= 0;
        if (mem_write) mem_array[mem_address] <= mem_writedata;
        else           mem_readdata <= mem_array[mem_address];
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_done <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected memory transactions
  typedef struct {
    bit          is_write;
    logic [5:0]  addr;
    logic [31:0] data;
  } mem_txn_t;
  mem_txn_t exp_q[$];

  task automatic push_txn(input bit is_wr, input logic [5:0] addr, input logic [31:0] data);
    mem_txn_t t;
    t.is_write = is_wr;
    t.addr     = addr;
    t.data     = data;
    exp_q.push_back(t);
  endtask

  // Compare each completed memory transfer against the oldest expectation.
  always @(negedge clk) begin
    if (reset && (mem_read || mem_write) && mem_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_txn: got addr 0x%0h write %0b expected no transfer", mem_address, mem_write);
      end else begin
        mem_txn_t t;
        t = exp_q.pop_front();
        checkOutput("txn_kind", 32'(mem_write), 32'(t.is_write));
        checkOutput("txn_addr", 32'(mem_address), 32'(t.addr));
        if (t.is_write) checkOutput("txn_wdata", mem_writedata, t.data);
      end
    end
  end

  typedef struct {
    int         busy_cycles;
    int         strobe_cycles;
    bit         timed_out;
    bit         saw_read;
    bit         saw_write;
    bit         saw_both;
    bit         wr_after_rd;
    logic [5:0] first_rd_addr;
    logic [5:0] first_wr_addr;
    logic [31:0] first_wr_data;
  } acc_t;

  // Drive one CPU request and hold it until busywait is low (bounded).
  task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr,
                               input logic [7:0] wd, output acc_t r);
    r.busy_cycles = 0; r.strobe_cycles = 0; r.timed_out = 1'b0;
    r.saw_read = 1'b0; r.saw_write = 1'b0; r.saw_both = 1'b0; r.wr_after_rd = 1'b0;
    r.first_rd_addr = '0; r.first_wr_addr = '0; r.first_wr_data = '0;
    @(posedge clk); #1;
    read = rd; write = wr; address = addr; writedata = wd;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      if (mem_read && mem_write) r.saw_both = 1'b1;
      if (mem_read && !r.saw_read) begin
        r.saw_read = 1'b1;
        r.first_rd_addr = mem_address;
      end
      if (mem_write) begin
        if (r.saw_read) r.wr_after_rd = 1'b1;
        if (!r.saw_write) begin
          r.saw_write = 1'b1;
          r.first_wr_addr = mem_address;
          r.first_wr_data = mem_writedata;
        end
      end
      if (!busywait) return;
      r.busy_cycles++;
      if (mem_read || mem_write) r.strobe_cycles++;
      @(posedge clk); #1;
    end
    r.timed_out = 1'b1;
  endtask

  task automatic release_req();
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t vecs[7];

  initial begin
    acc_t r;
    bit   seen;

    for (int b = 0; b < 64; b++) mem_array[b] = block_init(b);
    mem_readdata = '0;

    vecs[0] = '{1'b1, 1'b0, 8'h14, 8'h00, 8'hAA};
    vecs[1] = '{1'b1, 1'b0, 8'h15, 8'h00, 8'hBB};
    vecs[2] = '{1'b1, 1'b0, 8'h16, 8'h00, 8'hCC};
    vecs[3] = '{1'b1, 1'b0, 8'h17, 8'h00, 8'hDD};
    vecs[4] = '{1'b0, 1'b1, 8'h15, 8'h3C, 8'hDD};
    vecs[5] = '{1'b1, 1'b0, 8'h15, 8'h00, 8'h3C};
    vecs[6] = '{1'b1, 1'b0, 8'h14, 8'h00, 8'hAA};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_readdata", 32'(readdata), 32'h0);
    checkOutput("rst_busywait", 32'(busywait), 32'h0);
    checkOutput("rst_mem_read", 32'(mem_read), 32'h0);
    checkOutput("rst_mem_write", 32'(mem_write), 32'h0);
    checkOutput("rst_mem_address", 32'(mem_address), 32'h0);
    checkOutput("rst_mem_writedata", mem_writedata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Clean miss refill of block 5
    push_txn(1'b0, 6'h05, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h14, 8'h00, r);
    checkOutput("miss1_timeout", 32'(r.timed_out), 32'h0);
    checkOutput("miss1_stalled", 32'(r.busy_cycles > 0), 32'h1);
    checkOutput("miss1_saw_read", 32'(r.saw_read), 32'h1);
    checkOutput("miss1_no_write", 32'(r.saw_write), 32'h0);
    checkOutput("miss1_mem_addr", 32'(r.first_rd_addr), 32'h05);
    checkOutput("miss1_readdata", 32'(readdata), 32'hAA);
    checkOutput("miss1_strobe_cycles", 32'(r.strobe_cycles), 32'(MEM_LAT + 1));
    checkOutput("miss1_latency", 32'(r.busy_cycles), 32'(r.strobe_cycles + 2));

    // Read hit on the refilled line: same-cycle data, no stall
    applyStimulus(1'b1, 1'b0, 8'h17, 8'h00, r);
    checkOutput("hit_busy", 32'(r.busy_cycles), 32'h0);
    checkOutput("hit_no_mem", 32'(r.saw_read | r.saw_write), 32'h0);
    checkOutput("hit_readdata", 32'(readdata), 32'hDD);

    // Back-to-back hit vectors, including a store and the held read value
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, r);
      checkOutput($sformatf("vec%0d_busy", i), 32'(r.busy_cycles), 32'h0);
      checkOutput($sformatf("vec%0d_readdata", i), 32'(readdata), 32'(vecs[i].exp_rd));
    end
    release_req();

    // Dirty eviction: store to tag 1 of index 5 writes back the modified block
    push_txn(1'b1, 6'h05, 32'hDDCC3CAA);
    push_txn(1'b0, 6'h0D, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h35, 8'h77, r);
    checkOutput("evict_timeout", 32'(r.timed_out), 32'h0);
    checkOutput("evict_saw_write", 32'(r.saw_write), 32'h1);
    checkOutput("evict_wb_addr", 32'(r.first_wr_addr), 32'h05);
    checkOutput("evict_wb_data", r.first_wr_data, 32'hDDCC3CAA);
    checkOutput("evict_rd_addr", 32'(r.first_rd_addr), 32'h0D);
    checkOutput("evict_order", 32'(r.wr_after_rd), 32'h0);
    checkOutput("evict_exclusive", 32'(r.saw_both), 32'h0);
    checkOutput("evict_strobe_cycles", 32'(r.strobe_cycles), 32'(2 * (MEM_LAT + 1)));
    checkOutput("evict_latency", 32'(r.busy_cycles), 32'(r.strobe_cycles + 2));
    applyStimulus(1'b1, 1'b0, 8'h35, 8'h00, r);
    checkOutput("evict_store_readback", 32'(readdata), 32'h77);
    applyStimulus(1'b1, 1'b0, 8'h34, 8'h00, r);
    checkOutput("evict_other_byte", 32'(readdata), 32'h0D);
    release_req();

    // Evict back: the written-back block must come from memory intact
    push_txn(1'b1, 6'h0D, 32'h3D2D770D);
    push_txn(1'b0, 6'h05, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h15, 8'h00, r);
    checkOutput("reload_saw_write", 32'(r.saw_write), 32'h1);
    checkOutput("reload_readdata", 32'(readdata), 32'h3C);
    // Dirty the line so the reset below has something to discard
    applyStimulus(1'b0, 1'b1, 8'h14, 8'h99, r);
    checkOutput("dirty_store_busy", 32'(r.busy_cycles), 32'h0);
    release_req();

    // Reset while a refill is in progress
    @(posedge clk); #1;
    read = 1'b1; address = 8'h24;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_read) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checkOutput("rstmid_mem_read_seen", 32'(seen), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0; read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstmid_mem_read", 32'(mem_read), 32'h0);
    checkOutput("rstmid_mem_write", 32'(mem_write), 32'h0);
    checkOutput("rstmid_busywait", 32'(busywait), 32'h0);
    checkOutput("rstmid_mem_address", 32'(mem_address), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // After reset every line is invalid and the dirty byte was dropped
    push_txn(1'b0, 6'h05, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h14, 8'h00, r);
    checkOutput("post_rst_miss", 32'(r.busy_cycles > 0), 32'h1);
    checkOutput("post_rst_no_wb", 32'(r.saw_write), 32'h0);
    checkOutput("post_rst_rd_addr", 32'(r.first_rd_addr), 32'h05);
    checkOutput("post_rst_readdata", 32'(readdata), 32'hAA);

    // READ and WRITE together act as a store
    applyStimulus(1'b1, 1'b1, 8'h16, 8'h5A, r);
    checkOutput("rw_busy", 32'(r.busy_cycles), 32'h0);
    release_req();
    applyStimulus(1'b1, 1'b0, 8'h16, 8'h00, r);
    checkOutput("rw_readback", 32'(readdata), 32'h5A);
    release_req();
    push_txn(1'b1, 6'h05, 32'hDD5A3CAA);
    push_txn(1'b0, 6'h0D, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h36, 8'h00, r);
    checkOutput("rw_dirty_wb", 32'(r.saw_write), 32'h1);
    checkOutput("rw_evict_readdata", 32'(readdata), 32'h2D);
    release_req();

    repeat (2) @(posedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so a stuck design can never hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
